// File: rtl/mem_store_buffer.sv
// Write-back store buffer in front of the data memory: FIFO-queues stores and drains them to the
// single memory port when no load miss needs it, forwarding load hits from the youngest match.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid_i,
  input  logic [AW-1:0] st_addr_i,
  input  logic [DW-1:0] st_data_i,
  output logic          st_ready_o,
  input  logic          ld_valid_i,
  input  logic [AW-1:0] ld_addr_i,
  output logic          ld_hit_o,
  output logic [DW-1:0] ld_data_o,
  output logic          mem_write_o,
  output logic          mem_read_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     push, pop;

  assign empty_o    = (count_q == '0);
  assign st_ready_o = (count_q != CW'(DEPTH));
  assign count_o    = count_q;
  assign push       = st_valid_i & st_ready_o;

  // Walk entries oldest to youngest so the last match seen wins (youngest-first forwarding).
  always_comb begin
    logic [PW-1:0] idx;
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (ld_valid_i && (CW'(k) < count_q) && (addr_q[idx] == ld_addr_i)) begin
        ld_hit_o  = 1'b1;
        ld_data_o = data_q[idx];
      end
    end
  end

  // A load miss owns the port; otherwise the oldest entry drains.
  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    pop         = 1'b0;
    if (ld_valid_i && !ld_hit_o) begin
      mem_read_o = 1'b1;
      mem_addr_o = ld_addr_i;
    end else if (!empty_o) begin
      mem_write_o = 1'b1;
      mem_addr_o  = addr_q[rd_ptr_q];
      mem_wdata_o = data_q[rd_ptr_q];
      pop         = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        addr_q[wr_ptr_q] <= st_addr_i;
        data_q[wr_ptr_q] <= st_data_i;
      end
    end
  end

endmodule
